neuron_train_sequencer: RTL and testbench
=========================================

Name: neuron_train_sequencer

Overview:
- Controller that drives a training run of the perceptron Neuron datapath from an on-chip sample memory.
- Holds a preloaded dataset of (x1, x2, t) samples and issues the Neuron start pulse.
- Services the Neuron's requestFlag/dataReady handshake sample by sample, wrapping over epochs until the Neuron raises done or an epoch limit expires.
- Sits between a host/loader and one Neuron instance, replacing bench-driven feeding.

Parameters:
- DEPTH, 512, sample memory entries
- ADDR_W, 9, sample address width (clog2 DEPTH)
- X_W, 7, signed width of x1/x2
- T_W, 2, signed width of target t
- EPOCH_W, 8, epoch counter width
- MAX_EPOCHS, 64, epoch limit (used only with FEEDER_EPOCH_LIMIT_EN)
- START_CYC, 2, clock cycles n_start is held high

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- load_en  in  1  write one sample into memory (ignored while busy)
- load_addr  in  ADDR_W  write address
- load_x1  in  X_W  signed x1 to store
- load_x2  in  X_W  signed x2 to store
- load_t  in  T_W  signed target to store
- num_samples  in  ADDR_W+1  dataset size, sampled on accepted start
- start  in  1  begin training run (level; accepted only in IDLE)
- busy  out  1  run in progress
- finished  out  1  one-cycle pulse at end of run
- timeout  out  1  sticky: last run hit the epoch limit; cleared on next accepted start
- cfg_err  out  1  one-cycle pulse: start rejected
- epoch  out  EPOCH_W  completed-epoch count of current/last run
- n_start  out  1  to Neuron start
- n_count  out  32  to Neuron nInput (zero-extended num_samples)
- n_x1, n_x2  out  X_W  to Neuron x1Input/x2Input
- n_t  out  T_W  to Neuron tInput
- n_data_ready  out  1  to Neuron dataReady
- n_request  in  1  from Neuron requestFlag
- n_done  in  1  from Neuron done

Behaviour:
- Reset (async, any state): all outputs 0; state IDLE; idx=0; epoch=0; timeout=0. Memory contents undefined and not cleared.
- Memory: one write port, registered read with 1-cycle latency. Writes are accepted only in IDLE.
- States:
  - IDLE → START on start, provided 1 ≤ num_samples ≤ DEPTH. Otherwise cfg_err pulses and the block stays in IDLE.
  - On the IDLE→START edge: latch num_samples, idx=0, epoch=0, timeout=0, busy=1.
  - START: n_start=1 for exactly START_CYC cycles → WAIT_REQ.
  - WAIT_REQ: on n_request=1 issue a read of idx → FETCH.
  - FETCH: 1 cycle; capture memory data into n_x1/n_x2/n_t → PRESENT.
  - PRESENT: n_data_ready=1, data held stable; stay while n_request=1. When n_request=0 → RELEASE.
  - RELEASE: n_data_ready=0 for 1 cycle; idx advances. If idx == num_samples-1, wrap idx to 0 and increment epoch (saturating at all-ones) → WAIT_REQ.
  - DONE: finished=1 for 1 cycle, busy=0 → IDLE. n_x*/n_t keep their last values.
- n_count is held for the whole run, including IDLE after the run.
- n_done high in any of START..RELEASE: go to DONE next cycle and drop n_data_ready. n_done has priority over n_request in the same cycle.
- start and load_en while busy: ignored, no error.
- Minimum sample period is 4 cycles (WAIT_REQ→FETCH→PRESENT→RELEASE), assuming the Neuron drops n_request within one cycle.

Optional Feature:
- FEEDER_EPOCH_LIMIT_EN defined:
  - At RELEASE, if the incremented epoch == MAX_EPOCHS, set timeout=1 and go to DONE instead of WAIT_REQ.
  - n_done arriving in that same cycle takes priority: timeout stays 0.
- Undefined: no limit; the run ends only on n_done. timeout is tied to 0.

Decomposition:
- Package neuron_pkg holds:
  - X_W/T_W/W_W (14) width constants
  - sample_t struct {x1, x2, t}
  - sequencer state enum (IDLE, START, WAIT_REQ, FETCH, PRESENT, RELEASE, DONE)
- Sub-module neuron_sample_mem: DEPTH x sample_t, synchronous write, registered read.

Test Plan:
1. Load 4 samples, num_samples=4, start; model Neuron requests 10 times → samples 0,1,2,3,0,1,... presented in order, each held while n_request=1. epoch=2 after 8 samples; n_start high exactly 2 cycles.
2. num_samples=0 and separately 513, start → cfg_err one-cycle pulse, busy stays 0, n_start never asserted.
3. Model asserts n_done together with n_request during sample 3 → no FETCH; n_data_ready=0 next cycle; finished pulse; busy=0; timeout=0.
4. With FEEDER_EPOCH_LIMIT_EN, MAX_EPOCHS=3, num_samples=2, Neuron never done → finished after the 6th sample's RELEASE; timeout=1, epoch=3. Without the macro, still busy after 100 samples.
5. Assert rst mid-PRESENT → outputs 0 immediately (asynchronous), state IDLE. A subsequent start replays from sample 0 using the memory contents written before reset.
6. load_en with load_addr=0, new data, while busy → the in-flight run still presents the old sample 0 on its next epoch.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared widths, sample record and sequencer state encoding for the Neuron training path.
package neuron_pkg;
  localparam int X_W = 7;
  localparam int T_W = 2;
  localparam int W_W = 14;

  typedef struct packed {
    logic signed [X_W-1:0] x1;
    logic signed [X_W-1:0] x2;
    logic signed [T_W-1:0] t;
  } sample_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WAIT_REQ, ST_FETCH, ST_PRESENT, ST_RELEASE, ST_DONE
  } state_e;
endpackage

// File: rtl/neuron_sample_mem.sv
// Sample store: one synchronous write port, one registered read port (1-cycle latency).
module neuron_sample_mem
  import neuron_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  sample_t           wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output sample_t           rd_data
);
  // Contents are intentionally not reset so a dataset survives a controller reset.
  sample_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/neuron_train_sequencer.sv
// Drives a perceptron Neuron training run from preloaded samples, epoch after epoch.
// Optional epoch limit enabled by defining FEEDER_EPOCH_LIMIT_EN.
module neuron_train_sequencer #(
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = 9,
  parameter int X_W        = neuron_pkg::X_W,
  parameter int T_W        = neuron_pkg::T_W,
  parameter int EPOCH_W    = 8,
  parameter int MAX_EPOCHS = 64,
  parameter int START_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [X_W-1:0]     load_x1,
  input  logic [X_W-1:0]     load_x2,
  input  logic [T_W-1:0]     load_t,
  input  logic [ADDR_W:0]    num_samples,
  input  logic               start,
  output logic               busy,
  output logic               finished,
  output logic               timeout,
  output logic               cfg_err,
  output logic [EPOCH_W-1:0] epoch,
  output logic               n_start,
  output logic [31:0]        n_count,
  output logic [X_W-1:0]     n_x1,
  output logic [X_W-1:0]     n_x2,
  output logic [T_W-1:0]     n_t,
  output logic               n_data_ready,
  input  logic               n_request,
  input  logic               n_done
);
  import neuron_pkg::*;

  localparam int SC_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  state_e             state;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W:0]    ns;
  logic [EPOCH_W-1:0] epoch_inc;
  logic [SC_W-1:0]    scnt;
  logic               cfg_ok, last, rd_en, wr_en, timeout_q, lim_hit;
  sample_t            wr_data, rd_data;

  assign cfg_ok    = (num_samples != '0) && (num_samples <= (ADDR_W+1)'(DEPTH));
  assign last      = ({1'b0, idx} == ns - 1'b1);
  assign epoch_inc = (&epoch) ? epoch : epoch + 1'b1;
  assign wr_en     = load_en && (state == ST_IDLE);
  assign wr_data   = '{x1: load_x1, x2: load_x2, t: load_t};
  assign rd_en     = (state == ST_WAIT_REQ) && n_request && !n_done;

`ifdef FEEDER_EPOCH_LIMIT_EN
  assign lim_hit = (epoch_inc == EPOCH_W'(MAX_EPOCHS));
`else
  assign lim_hit = 1'b0;
`endif

  neuron_sample_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (load_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  assign busy         = (state != ST_IDLE) && (state != ST_DONE);
  assign finished     = (state == ST_DONE);
  assign n_start      = (state == ST_START);
  assign n_data_ready = (state == ST_PRESENT);
  assign n_count      = {{(31-ADDR_W){1'b0}}, ns};
  assign timeout      = timeout_q;

  // n_done preempts every in-run state, including the handshake and epoch bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      ns        <= '0;
      epoch     <= '0;
      scnt      <= '0;
      timeout_q <= 1'b0;
      cfg_err   <= 1'b0;
      n_x1      <= '0;
      n_x2      <= '0;
      n_t       <= '0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          if (cfg_ok) begin
            state     <= ST_START;
            ns        <= num_samples;
            idx       <= '0;
            epoch     <= '0;
            scnt      <= '0;
            timeout_q <= 1'b0;
          end else begin
            cfg_err <= 1'b1;
          end
        end
        ST_START: begin
          if (n_done)                           state <= ST_DONE;
          else if (scnt == SC_W'(START_CYC-1)) state <= ST_WAIT_REQ;
          else                                  scnt  <= scnt + 1'b1;
        end
        ST_WAIT_REQ: begin
          if (n_done)         state <= ST_DONE;
          else if (n_request) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (n_done) state <= ST_DONE;
          else begin
            n_x1  <= rd_data.x1;
            n_x2  <= rd_data.x2;
            n_t   <= rd_data.t;
            state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (n_done)          state <= ST_DONE;
          else if (!n_request) state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (n_done) state <= ST_DONE;
          else if (last) begin
            idx   <= '0;
            epoch <= epoch_inc;
            if (lim_hit) begin
              timeout_q <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_WAIT_REQ;
            end
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_WAIT_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_train_sequencer.sv
// Directed bench: a behavioural Neuron requests samples, a queue holds the expected data.
module tb_neuron_train_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        load_en = 1'b0, start = 1'b0, n_request = 1'b0, n_done = 1'b0;
  logic [8:0]  load_addr = '0;
  logic [6:0]  load_x1 = '0, load_x2 = '0;
  logic [1:0]  load_t = '0;
  logic [9:0]  num_samples = '0;
  logic        busy, finished, timeout, cfg_err, n_start, n_data_ready;
  logic [7:0]  epoch;
  logic [31:0] n_count;
  logic [6:0]  n_x1, n_x2;
  logic [1:0]  n_t;

  neuron_train_sequencer #(.MAX_EPOCHS(3)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_x1(load_x1), .load_x2(load_x2), .load_t(load_t),
    .num_samples(num_samples), .start(start), .busy(busy), .finished(finished),
    .timeout(timeout), .cfg_err(cfg_err), .epoch(epoch), .n_start(n_start),
    .n_count(n_count), .n_x1(n_x1), .n_x2(n_x2), .n_t(n_t),
    .n_data_ready(n_data_ready), .n_request(n_request), .n_done(n_done)
  );

  always #5 clk = ~clk;

  int          n_assert = 0, n_fail = 0;
  logic [31:0] sb[$];
  logic [6:0]  mx1 [8], mx2 [8];
  logic [1:0]  mt [8];
  int          exp_idx = 0, exp_ns = 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pack_dut();
    return {16'b0, n_x1, n_x2, n_t};
  endfunction

  task automatic load(int a, logic [6:0] x1, logic [6:0] x2, logic [1:0] t, bit accept);
    load_en = 1'b1; load_addr = 9'(a); load_x1 = x1; load_x2 = x2; load_t = t;
    tick();
    load_en = 1'b0;
    if (accept) begin mx1[a] = x1; mx2[a] = x2; mt[a] = t; end
  endtask

  task automatic start_run(int ns);
    int cnt;
    num_samples = 10'(ns); start = 1'b1;
    tick();
    start = 1'b0; exp_idx = 0; exp_ns = ns; sb.delete();
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_timeout_clr", 32'(timeout), 32'd0);
    chk("run_epoch0", 32'(epoch), 32'd0);
    chk("run_n_count", n_count, 32'(ns));
    cnt = 0;
    while (n_start && cnt < 10) begin cnt++; tick(); end
    chk("n_start_cycles", 32'(cnt), 32'd2);
  endtask

  // Request one sample, wait for it, check it over the hold window, release.
  task automatic serve_one(int hold);
    int w;
    logic [31:0] e;
    n_request = 1'b1;
    sb.push_back({16'b0, mx1[exp_idx], mx2[exp_idx], mt[exp_idx]});
    exp_idx = (exp_idx + 1) % exp_ns;
    w = 0;
    while (!n_data_ready && w < 10) begin w++; tick(); end
    chk("data_ready_wait", 32'(n_data_ready), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : 32'hdead_beef;
    chk("sample", pack_dut(), e);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("sample_hold", pack_dut(), e);
      chk("hold_ready", 32'(n_data_ready), 32'd1);
    end
    n_request = 1'b0;
    tick();
    chk("release_ready", 32'(n_data_ready), 32'd0);
  endtask

  task automatic serve(int n);
    for (int i = 0; i < n; i++) serve_one(i % 3);
  endtask

  task automatic end_run();
    n_done = 1'b1;
    tick();
    chk("end_finished", 32'(finished), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_ready", 32'(n_data_ready), 32'd0);
    n_done = 1'b0;
    tick();
    chk("end_finished_pulse", 32'(finished), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outputs", {n_start, n_data_ready, finished, cfg_err, timeout}, 32'd0);
    chk("rst_epoch", 32'(epoch), 32'd0);
    chk("rst_n_count", n_count, 32'd0);
    chk("rst_data", pack_dut(), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    load(0, 7'd5,         7'(-3),  2'd1,    1'b1);
    load(1, 7'(-64),      7'd63,   2'(-1),  1'b1);
    load(2, 7'd0,         7'(-1),  2'(-2),  1'b1);
    load(3, 7'd12,        7'd34,   2'd0,    1'b1);

    // in-order presentation with wrap, epoch count after 8 samples
    start_run(4);
    serve(8);
    tick();
    chk("epoch_after_8", 32'(epoch), 32'd2);
    serve(2);
    end_run();
    chk("epoch_after_run", 32'(epoch), 32'd2);

    // rejected starts
    for (int k = 0; k < 2; k++) begin
      num_samples = (k == 0) ? 10'd0 : 10'd513; start = 1'b1;
      tick();
      start = 1'b0;
      chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
      chk("cfg_err_busy", 32'(busy), 32'd0);
      chk("cfg_err_n_start", 32'(n_start), 32'd0);
      tick();
      chk("cfg_err_clear", 32'(cfg_err), 32'd0);
      chk("cfg_err_n_start2", 32'(n_start), 32'd0);
    end

    // n_done together with a request: no fetch, run ends
    start_run(4);
    serve(3);
    tick();
    n_request = 1'b1; n_done = 1'b1;
    tick();
    chk("done_finished", 32'(finished), 32'd1);
    chk("done_ready", 32'(n_data_ready), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_timeout", 32'(timeout), 32'd0);
    chk("done_data_kept", pack_dut(), {16'b0, mx1[2], mx2[2], mt[2]});
    n_request = 1'b0; n_done = 1'b0;
    tick();
    chk("done_idle", 32'(finished | busy), 32'd0);

    // writes while busy are ignored
    start_run(4);
    serve(2);
    load(0, 7'd99, 7'd98, 2'd1, 1'b0);
    serve(4);
    end_run();

    // epoch limit
    start_run(2);
`ifdef FEEDER_EPOCH_LIMIT_EN
    serve(6);
    tick();
    chk("lim_finished", 32'(finished), 32'd1);
    chk("lim_timeout", 32'(timeout), 32'd1);
    chk("lim_epoch", 32'(epoch), 32'd3);
    chk("lim_busy", 32'(busy), 32'd0);
    tick();
    chk("lim_timeout_sticky", 32'(timeout), 32'd1);
    chk("lim_finished_pulse", 32'(finished), 32'd0);
`else
    serve(100);
    tick();
    chk("nolim_busy", 32'(busy), 32'd1);
    chk("nolim_epoch", 32'(epoch), 32'd50);
    chk("nolim_timeout", 32'(timeout), 32'd0);
    end_run();
`endif

    // asynchronous reset mid-PRESENT, then replay from retained memory
    start_run(4);
    serve(1);
    begin
      int w;
      logic [31:0] e;
      n_request = 1'b1;
      sb.push_back({16'b0, mx1[1], mx2[1], mt[1]});
      w = 0;
      while (!n_data_ready && w < 10) begin w++; tick(); end
      chk("pre_rst_ready", 32'(n_data_ready), 32'd1);
      e = (sb.size() > 0) ? sb.pop_front() : 32'hdead_beef;
      chk("pre_rst_sample", pack_dut(), e);
    end
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(n_data_ready), 32'd0);
    chk("arst_data", pack_dut(), 32'd0);
    chk("arst_n_count", n_count, 32'd0);
    chk("arst_epoch", 32'(epoch), 32'd0);
    n_request = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    start_run(4);
    serve(4);
    end_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
